// File: rtl/run_ctrl_pkg.sv
// Shared types and widths for the run controller and its bench.
package run_ctrl_pkg;

  localparam int PC_W  = 32;
  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN,
    DONE
  } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and optional saturation at all-ones.
module sat_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic at_max;

  assign at_max = SATURATE && (&count);

  // NOTE: non-blocking so every register in the design samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run-sequencing FSM: arm, run until halt/PC overrun, drain, report done.
// Optional watchdog (MAX_CYCLES, timeout) is built when RUN_CTRL_WATCHDOG_EN is defined.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int PROG_LEN     = 256,
  parameter int DRAIN_CYCLES = 2
`ifdef RUN_CTRL_WATCHDOG_EN
  ,
  parameter logic [CNT_W-1:0] MAX_CYCLES = 32'd1_000_000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_instr,
  input  logic [PC_W-1:0]  pc,
  output logic             should_run_processor,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic             timeout
);

  localparam logic [PC_W-1:0] PROG_END   = PC_W'(PROG_LEN);
  localparam logic [3:0]      DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  run_state_t state_q, state_d;
  logic [3:0] drain_cnt;
  logic       halt_hit;
  logic       run_end;
  logic       arm_entry;

  assign halt_hit  = halt_instr || (pc >= PROG_END);
  assign arm_entry = (state_q != ARM) && (state_d == ARM);

`ifdef RUN_CTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = MAX_CYCLES - CNT_W'(1);

  logic wd_hit;
  logic timeout_q;

  assign wd_hit  = (cycle_count == WD_LAST);
  assign run_end = halt_hit || wd_hit;

  // Halt wins over a coincident watchdog expiry, so that run is not a timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (arm_entry) begin
      timeout_q <= 1'b0;
    end else if (state_q == RUN && wd_hit && !halt_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign run_end = halt_hit;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d              = state_q;
    should_run_processor = 1'b0;
    done                 = 1'b0;
    busy                 = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = ARM;
      end
      ARM: begin
        busy = 1'b1;
        if (!start) state_d = RUN;
      end
      RUN: begin
        busy                 = 1'b1;
        should_run_processor = 1'b1;
        if (run_end) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = ARM;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts every RUN cycle, including the one that detects the halt.
  sat_counter #(
    .WIDTH   (CNT_W),
    .SATURATE(1'b1)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (arm_entry),
    .enable(state_q == RUN),
    .count (cycle_count)
  );

  // Held at zero outside DRAIN, so each drain starts counting from 0.
  sat_counter #(
    .WIDTH   (4),
    .SATURATE(1'b1)
  ) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != DRAIN),
    .enable(state_q == DRAIN),
    .count (drain_cnt)
  );

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller (PROG_LEN=16, DRAIN_CYCLES=2; MAX_CYCLES=20 under RUN_CTRL_WATCHDOG_EN).
module tb_run_controller;
  import run_ctrl_pkg::*;

  logic             clk;
  logic             reset;
  logic             start;
  logic             halt_instr;
  logic [PC_W-1:0]  pc;
  logic             should_run_processor;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] cycle_count;
  logic             timeout;

  int n_vec = 0;
  int n_err = 0;

  run_controller #(
    .PROG_LEN    (16),
    .DRAIN_CYCLES(2)
`ifdef RUN_CTRL_WATCHDOG_EN
    ,
    .MAX_CYCLES  (32'd20)
`endif
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .halt_instr          (halt_instr),
    .pc                  (pc),
    .should_run_processor(should_run_processor),
    .done                (done),
    .busy                (busy),
    .cycle_count         (cycle_count),
    .timeout             (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start high for n cycles (entering and holding ARM), then dropped to launch.
  task automatic arm(input int n);
    start = 1'b1;
    repeat (n) tick();
    start = 1'b0;
  endtask

  // Drives halt/pc per RUN cycle until done rises or max_s samples elapse.
  // noise: toggle start every cycle and drive junk halt/pc outside RUN.
  task automatic run_program(input int halt_at, input bit ramp_pc, input bit noise,
                             input int max_s, output int run_n, output int done_at);
    run_n   = 0;
    done_at = -1;
    for (int s = 1; s <= max_s; s++) begin
      tick();
      if (done) begin
        done_at    = s;
        start      = 1'b0;
        halt_instr = 1'b0;
        pc         = '0;
        break;
      end
      if (should_run_processor) begin
        run_n++;
        halt_instr = (run_n == halt_at);
        pc         = ramp_pc ? PC_W'(run_n - 1) : '0;
      end else begin
        halt_instr = noise;
        pc         = noise ? '1 : '0;
      end
      if (noise) start = ~start;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    n_vec++;
    if ({should_run_processor, done, busy, timeout, cycle_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got srp=%0b done=%0b busy=%0b to=%0b cnt=%0d, expected all 0",
               should_run_processor, done, busy, timeout, cycle_count);
    end
    @(posedge clk);
    #1;
    reset      = 1'b0;
    start      = 1'b0;
    halt_instr = 1'b0;
    pc         = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; halt_instr = 1'b0; pc = '0;
    repeat (2) tick();
    n_vec++;
    if ({should_run_processor, done, busy, timeout, cycle_count} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got srp=%0b done=%0b busy=%0b to=%0b cnt=%0d, expected all 0",
               should_run_processor, done, busy, timeout, cycle_count);
    end
    reset = 1'b0;
    start = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_release_no_move: busy=%0b expected 0", busy);
    end
    tick();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL idle_to_arm: busy=%0b expected 1", busy);
    end
    pulse_reset();
  endtask

  task automatic test_basic_run();
    int run_n, done_at;
    start = 1'b1;
    tick();
    n_vec++;
    if ({busy, should_run_processor, done, cycle_count} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL arm_outputs: got busy=%0b srp=%0b done=%0b cnt=%0d, expected 1 0 0 0",
               busy, should_run_processor, done, cycle_count);
    end
    repeat (2) tick();
    start = 1'b0;
    run_program(10, 1'b0, 1'b0, 40, run_n, done_at);
    n_vec++;
    if (run_n !== 10) begin
      n_err++; $display("FAIL basic_srp_cycles: got %0d expected 10", run_n);
    end
    n_vec++;
    if (done_at !== 13) begin
      n_err++; $display("FAIL basic_done_latency: got sample %0d expected 13", done_at);
    end
    n_vec++;
    if (cycle_count !== 32'd10) begin
      n_err++; $display("FAIL basic_count: got %0d expected 10", cycle_count);
    end
    tick();
    n_vec++;
    if ({done, busy, timeout} !== 3'b100) begin
      n_err++; $display("FAIL basic_done_hold: got done/busy/to=%03b expected 100", {done, busy, timeout});
    end
  endtask

  task automatic test_rearm_from_done();
    int run_n, done_at;
    start = 1'b1;
    tick();
    n_vec++;
    if ({done, busy, cycle_count} !== {1'b0, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL rearm_entry: got done=%0b busy=%0b cnt=%0d expected 0 1 0", done, busy, cycle_count);
    end
    repeat (2) tick();
    start = 1'b0;
    run_program(4, 1'b0, 1'b0, 40, run_n, done_at);
    n_vec++;
    if ({run_n, done_at} !== {32'd4, 32'd7}) begin
      n_err++; $display("FAIL rearm_timing: got run=%0d done_at=%0d expected 4 7", run_n, done_at);
    end
    n_vec++;
    if (cycle_count !== 32'd4) begin
      n_err++; $display("FAIL rearm_count: got %0d expected 4", cycle_count);
    end
  endtask

  task automatic test_start_ignored();
    int run_n, done_at;
    arm(3);
    run_program(6, 1'b0, 1'b1, 40, run_n, done_at);
    n_vec++;
    if ({run_n, done_at} !== {32'd6, 32'd9}) begin
      n_err++; $display("FAIL noise_timing: got run=%0d done_at=%0d expected 6 9", run_n, done_at);
    end
    n_vec++;
    if (cycle_count !== 32'd6) begin
      n_err++; $display("FAIL noise_count: got %0d expected 6", cycle_count);
    end
    tick();
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL noise_done_hold: got %0b expected 1", done);
    end
  endtask

  task automatic test_pc_overrun();
    int run_n, done_at;
    arm(3);
    run_program(0, 1'b1, 1'b0, 40, run_n, done_at);
    n_vec++;
    if ({run_n, done_at} !== {32'd17, 32'd20}) begin
      n_err++; $display("FAIL overrun_timing: got run=%0d done_at=%0d expected 17 20", run_n, done_at);
    end
    n_vec++;
    if ({done, cycle_count} !== {1'b1, 32'd17}) begin
      n_err++; $display("FAIL overrun_result: got done=%0b cnt=%0d expected 1 17", done, cycle_count);
    end
  endtask

  task automatic test_reset_mid_run();
    int run_n, done_at;
    arm(3);
    run_program(0, 1'b0, 1'b0, 5, run_n, done_at);
    n_vec++;
    if ({should_run_processor, cycle_count} !== {1'b1, 32'd4}) begin
      n_err++; $display("FAIL run5_state: got srp=%0b cnt=%0d expected 1 4", should_run_processor, cycle_count);
    end
    pulse_reset();
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: busy=%0b expected 0", busy);
    end
    arm(3);
    run_program(3, 1'b0, 1'b0, 40, run_n, done_at);
    n_vec++;
    if ({run_n, done_at, cycle_count} !== {32'd3, 32'd6, 32'd3}) begin
      n_err++;
      $display("FAIL fresh_run: got run=%0d done_at=%0d cnt=%0d expected 3 6 3", run_n, done_at, cycle_count);
    end
  endtask

  task automatic test_reset_mid_drain();
    int run_n, done_at;
    arm(3);
    run_program(2, 1'b0, 1'b0, 3, run_n, done_at);
    n_vec++;
    if ({busy, should_run_processor, done, cycle_count} !== {1'b1, 1'b0, 1'b0, 32'd2}) begin
      n_err++;
      $display("FAIL drain_state: got busy=%0b srp=%0b done=%0b cnt=%0d expected 1 0 0 2",
               busy, should_run_processor, done, cycle_count);
    end
    pulse_reset();
  endtask

`ifdef RUN_CTRL_WATCHDOG_EN
  task automatic test_watchdog();
    int run_n, done_at;
    arm(3);
    run_program(0, 1'b0, 1'b0, 60, run_n, done_at);
    n_vec++;
    if ({run_n, done_at} !== {32'd20, 32'd23}) begin
      n_err++; $display("FAIL wd_timing: got run=%0d done_at=%0d expected 20 23", run_n, done_at);
    end
    n_vec++;
    if ({timeout, cycle_count} !== {1'b1, 32'd20}) begin
      n_err++; $display("FAIL wd_result: got to=%0b cnt=%0d expected 1 20", timeout, cycle_count);
    end
    start = 1'b1;
    tick();
    n_vec++;
    if ({timeout, cycle_count} !== {1'b0, 32'd0}) begin
      n_err++; $display("FAIL wd_arm_clear: got to=%0b cnt=%0d expected 0 0", timeout, cycle_count);
    end
    repeat (2) tick();
    start = 1'b0;
    run_program(20, 1'b0, 1'b0, 60, run_n, done_at);
    n_vec++;
    if ({timeout, cycle_count, done_at} !== {1'b0, 32'd20, 32'd23}) begin
      n_err++;
      $display("FAIL wd_halt_priority: got to=%0b cnt=%0d done_at=%0d expected 0 20 23", timeout, cycle_count, done_at);
    end
  endtask
`else
  task automatic test_no_watchdog();
    int run_n, done_at;
    arm(3);
    run_program(0, 1'b0, 1'b0, 40, run_n, done_at);
    n_vec++;
    if ({run_n, done_at} !== {32'd40, -32'sd1}) begin
      n_err++; $display("FAIL nowd_still_running: got run=%0d done_at=%0d expected 40 -1", run_n, done_at);
    end
    n_vec++;
    if ({should_run_processor, timeout, cycle_count} !== {1'b1, 1'b0, 32'd39}) begin
      n_err++;
      $display("FAIL nowd_state: got srp=%0b to=%0b cnt=%0d expected 1 0 39", should_run_processor, timeout, cycle_count);
    end
    pulse_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_run();
    test_rearm_from_done();
    test_start_ignored();
    test_pc_overrun();
    test_reset_mid_run();
    test_reset_mid_drain();
`ifdef RUN_CTRL_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion before 200000");
    $fatal(1, "bench time limit expired");
  end

endmodule
